branch_resolve: RTL and testbench

- Downstream consumer of the status register's condition-pass output (`we_o`).
- Resolves conditional and unconditional branches in the resolve stage and issues a one-cycle PC redirect.
- Squashes the younger in-flight pipeline stages for a fixed number of cycles.
- Gates register-file writeback of conditionally executed instructions.
- Sits between the status register and the fetch/PC logic and register-file write port.

---
 rtl/branch_resolve.sv | 90 +++++++++
 tb/tb_branch_resolve.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolve stage: decides taken/not-taken, issues a one-cycle PC
// redirect, squashes younger stages for FLUSH_DEPTH cycles and gates
// register-file writeback of conditionally executed instructions.
//
// state | meaning
// IDLE  | waiting for a branch in the resolve stage
// FLUSH | younger stages squashed, branches ignored
module branch_resolve #(
    parameter int PC_WIDTH    = 9,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid_i,
    input  logic                 br_uncond_i,
    input  logic                 cond_pass_i,
    input  logic [PC_WIDTH-1:0]  br_target_i,
    input  logic                 wb_we_i,
    input  logic                 cond_exec_i,
    output logic                 pc_load_o,
    output logic [PC_WIDTH-1:0]  pc_target_o,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic                 rf_we_o,
    output logic [CNT_WIDTH-1:0] taken_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // FLUSH_DEPTH tops out at 15, so four bits always hold the count.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       take;

    assign take = br_valid_i & (br_uncond_i | cond_pass_i);

    // Flushed instructions never write; conditional ones only when the condition passes.
    assign rf_we_o = wb_we_i & ~flush_o & (~cond_exec_i | cond_pass_i);

    // Branch FSM with registered redirect, flush and taken counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            pc_load_o   <= 1'b0;
            pc_target_o <= '0;
            flush_o     <= 1'b0;
            busy_o      <= 1'b0;
            taken_cnt_o <= '0;
        end else begin
            pc_load_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state       <= FLUSH;
                        flush_cnt   <= FLUSH_LOAD;
                        pc_load_o   <= 1'b1;
                        pc_target_o <= br_target_i;
                        flush_o     <= 1'b1;
                        busy_o      <= 1'b1;
                        if (taken_cnt_o != '1) begin
                            taken_cnt_o <= taken_cnt_o + CNT_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: cycle-by-cycle reference with an expected-
// output queue, a vector table for writeback gating, and hand-written
// sequences for flush overlap, reset mid-flush and counter saturation.
module tb_branch_resolve;

    localparam int PW  = 9;
    localparam int FD  = 3;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          br_valid_i = 1'b0;
    logic          br_uncond_i = 1'b0;
    logic          cond_pass_i = 1'b0;
    logic [PW-1:0] br_target_i = '0;
    logic          wb_we_i = 1'b0;
    logic          cond_exec_i = 1'b0;
    logic          pc_load_o;
    logic [PW-1:0] pc_target_o;
    logic          flush_o;
    logic          busy_o;
    logic          rf_we_o;
    logic [CW-1:0] taken_cnt_o;

    int errors = 0;
    int checks = 0;

    branch_resolve #(.PC_WIDTH(PW), .FLUSH_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .br_valid_i(br_valid_i), .br_uncond_i(br_uncond_i),
        .cond_pass_i(cond_pass_i), .br_target_i(br_target_i),
        .wb_we_i(wb_we_i), .cond_exec_i(cond_exec_i),
        .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
        .flush_o(flush_o), .busy_o(busy_o), .rf_we_o(rf_we_o),
        .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            load;
        logic [PW-1:0] target;
        bit            flush;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];

    // Reference state: m_left = flush cycles still to be shown.
    int            m_left = 0;
    bit            m_load = 0;
    logic [PW-1:0] m_target = '0;
    int            m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check rf_we, predict, clock, compare.
    task automatic step(input bit r, input bit v, input bit u, input bit cp,
                        input logic [PW-1:0] t, input bit wb, input bit ce);
        exp_t e;
        bit   exp_rf;
        rst = r; br_valid_i = v; br_uncond_i = u; cond_pass_i = cp;
        br_target_i = t; wb_we_i = wb; cond_exec_i = ce;
        #1;
        exp_rf = wb & (m_left == 0) & (~ce | cp);
        chk("rf_we", {31'd0, rf_we_o}, {31'd0, exp_rf});
        if (r) begin
            m_left = 0; m_load = 0; m_target = '0; m_cnt = 0;
        end else if (m_left == 0 && v && (u || cp)) begin
            m_load = 1; m_target = t; m_left = FD;
            if (m_cnt < 15) m_cnt++;
        end else begin
            m_load = 0;
            if (m_left > 0) m_left--;
        end
        e.load = m_load; e.target = m_target; e.flush = (m_left > 0);
        e.cnt = CW'(m_cnt);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("pc_load", {31'd0, pc_load_o}, {31'd0, e.load});
        chk("pc_target", {23'd0, pc_target_o}, {23'd0, e.target});
        chk("flush", {31'd0, flush_o}, {31'd0, e.flush});
        chk("busy", {31'd0, busy_o}, {31'd0, e.flush});
        chk("taken_cnt", {28'd0, taken_cnt_o}, {28'd0, e.cnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
    endtask

    typedef struct {
        bit wb;
        bit ce;
        bit cp;
        bit exp_idle;
    } rf_vec_t;

    rf_vec_t rf_tab[6];

    initial begin
        rf_tab[0] = '{1, 1, 0, 0};
        rf_tab[1] = '{1, 1, 1, 1};
        rf_tab[2] = '{1, 0, 0, 1};
        rf_tab[3] = '{1, 0, 1, 1};
        rf_tab[4] = '{0, 0, 1, 0};
        rf_tab[5] = '{0, 1, 1, 0};

        // Reset, then conditional taken branch to 0x0A5
        step(1, 0, 0, 0, '0, 0, 0);
        step(1, 0, 0, 0, '0, 0, 0);
        step(0, 1, 0, 1, 9'h0A5, 0, 0);
        chk("t1_load", {31'd0, pc_load_o}, 32'd1);
        chk("t1_target", {23'd0, pc_target_o}, 32'h0A5);
        chk("t1_cnt", {28'd0, taken_cnt_o}, 32'd1);
        idle(2);
        chk("t1_flush_last", {31'd0, flush_o}, 32'd1);
        idle(1);
        chk("t1_flush_end", {31'd0, flush_o}, 32'd0);

        // Not taken, then unconditional taken with cond_pass low
        step(0, 1, 0, 0, 9'h077, 0, 0);
        chk("t2_nottaken", {31'd0, pc_load_o}, 32'd0);
        step(0, 0, 1, 0, 9'h133, 0, 0);
        step(0, 1, 1, 0, 9'h1FF, 0, 0);
        chk("t2_uncond", {23'd0, pc_target_o}, 32'h1FF);
        idle(3);

        // Branch in last flush cycle ignored, next one accepted
        step(0, 1, 0, 1, 9'h010, 0, 0);
        idle(2);
        step(0, 1, 1, 0, 9'h020, 0, 0);
        chk("t3_ignored", {23'd0, pc_target_o}, 32'h010);
        step(0, 1, 1, 0, 9'h030, 0, 0);
        chk("t3_accept", {23'd0, pc_target_o}, 32'h030);
        chk("t3_load", {31'd0, pc_load_o}, 32'd1);

        // Writeback gating while flushing (table applied with flush high)
        for (int i = 0; i < 2; i++)
            step(0, 0, 0, rf_tab[i].cp, '0, rf_tab[i].wb, rf_tab[i].ce);
        idle(1);
        // Writeback gating while idle
        foreach (rf_tab[i]) begin
            step(0, 0, 0, rf_tab[i].cp, '0, rf_tab[i].wb, rf_tab[i].ce);
            wb_we_i = rf_tab[i].wb; cond_exec_i = rf_tab[i].ce; cond_pass_i = rf_tab[i].cp;
            #1;
            chk("rf_tab", {31'd0, rf_we_o}, {31'd0, rf_tab[i].exp_idle});
        end
        // Branch instruction itself writes back in its own cycle
        step(0, 1, 1, 0, 9'h044, 1, 0);
        chk("flush_gate", {31'd0, flush_o}, 32'd1);
        step(0, 0, 0, 1, '0, 1, 0);
        idle(2);

        // Reset mid-flush, then branch right after reset
        step(0, 1, 1, 0, 9'h0AA, 0, 0);
        step(0, 0, 0, 0, '0, 0, 0);
        step(1, 0, 0, 0, '0, 0, 0);
        chk("t5_flush", {31'd0, flush_o}, 32'd0);
        chk("t5_cnt", {28'd0, taken_cnt_o}, 32'd0);
        step(0, 1, 0, 1, 9'h0BB, 0, 0);
        chk("t5_accept", {23'd0, pc_target_o}, 32'h0BB);
        idle(3);

        // Saturation: 17 spaced taken branches after reset
        step(1, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 1, 0, PW'(i), 0, 0);
            idle(3);
        end
        chk("t6_sat", {28'd0, taken_cnt_o}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
